// File: rtl/fft_reorder_unload.sv
// fft_reorder_unload: output reorder buffer for the FFT datapath.
// Captures one frame of 2^N_LOG2 samples arriving in bit-reversed index
// order and replays it in natural index order on a valid/ready stream.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// exactly when valid and ready are both high at that edge. A producer keeps
// data stable while valid is high and ready is low; ready never depends on
// valid of the same port.
module fft_reorder_unload #(
  parameter int N_LOG2     = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

  // FILL collects a frame, DRAIN replays it; busy mirrors the state so the
  // FSM is directly observable at the port.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [N_LOG2-1:0]     wr_idx;
  logic [N_LOG2-1:0]     wr_idx_next;
  logic [N_LOG2-1:0]     rd_idx;
  logic [N_LOG2-1:0]     rd_idx_next;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] mem [N];

  // Bit n of the result is bit N_LOG2-1-n of k.
  function automatic logic [N_LOG2-1:0] rev(input logic [N_LOG2-1:0] k);
    logic [N_LOG2-1:0] r;
    for (int n = 0; n < N_LOG2; n++) begin
      r[n] = k[N_LOG2-1-n];
    end
    return r;
  endfunction

  // A sample is taken only in FILL and never while reset is held, since
  // in_ready is forced low during reset.
  assign write_en = (state == FILL) && in_valid && rst_n;

  // Next-state, counter updates and stream outputs.
  always_comb begin
    state_next  = state;
    wr_idx_next = wr_idx;
    rd_idx_next = rd_idx;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    busy        = 1'b0;
    case (state)
      FILL: begin
        in_ready = rst_n;
        if (write_en) begin
          wr_idx_next = wr_idx + 1'b1;
          if (wr_idx == LAST_IDX) begin
            state_next  = DRAIN;
            rd_idx_next = '0;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        out_last  = (rd_idx == LAST_IDX);
        busy      = 1'b1;
        if (out_ready) begin
          rd_idx_next = rd_idx + 1'b1;
          if (rd_idx == LAST_IDX) begin
            state_next = FILL;
          end
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // State and index registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      state  <= state_next;
      wr_idx <= wr_idx_next;
      rd_idx <= rd_idx_next;
    end
  end

  // Sample storage: scatter on write by reversed index, so a linear read
  // yields natural order. Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[rev(wr_idx)] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_reorder_unload.sv
// Directed bench for fft_reorder_unload: a N=4 instance covers reorder,
// backpressure, gaps, DRAIN lockout, back-to-back framing and reset; a N=8
// instance covers the wider permutation.
module tb_fft_reorder_unload;

  logic       clk = 1'b0;
  logic       rst_n;

  // N_LOG2 = 2 instance
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  // N_LOG2 = 3 instance
  logic [7:0] in8_data;
  logic       in8_valid;
  logic       in8_ready;
  logic [7:0] out8_data;
  logic       out8_valid;
  logic       out8_ready;
  logic       out8_last;
  logic       busy8;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected responses as {last, data}.
  logic [8:0] exp_q[$];
  logic [8:0] exp8_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_reorder_unload #(.N_LOG2(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  fft_reorder_unload #(.N_LOG2(3), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in8_data), .in_valid(in8_valid), .in_ready(in8_ready),
    .out_data(out8_data), .out_valid(out8_valid), .out_ready(out8_ready),
    .out_last(out8_last), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  bit         mon_en       = 0;
  bit         check_period = 0;
  int         in_idx       = 0;
  int         last_in_cyc  = -100;
  int         frame_start  = -1;
  logic       p_ov = 0, p_or = 0, p_last = 0, p_rst = 0;
  logic [7:0] p_data = '0;
  logic [8:0] got_e;
  logic [8:0] got8_e;

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_vs_state", {31'd0, in_ready}, {31'd0, rst_n & ~busy});
      check("out_valid_vs_busy", {31'd0, out_valid}, {31'd0, busy});
      if (!out_valid) check("idle_outputs_zero", {23'd0, out_last, out_data}, 32'd0);
      if (out_valid && !p_ov) check("first_output_latency", cyc, last_in_cyc + 1);
      if (p_ov && !p_or && p_rst)
        check("stall_stable", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, p_last, p_data});
      if (p_ov && p_or && p_rst && !p_last) check("consecutive_output", {31'd0, out_valid}, 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected none", out_data);
        end else begin
          got_e = exp_q.pop_front();
          check("out_data_last", {23'd0, out_last, out_data}, {23'd0, got_e});
        end
      end
      if (!rst_n) begin
        in_idx = 0;
      end else if (in_valid && in_ready) begin
        if (in_idx == 0) begin
          if (check_period && frame_start >= 0) check("frame_period", cyc - frame_start, 32'd8);
          frame_start = cyc;
        end
        if (in_idx == 3) last_in_cyc = cyc;
        in_idx = (in_idx + 1) % 4;
      end
      if (out8_valid && out8_ready) begin
        if (exp8_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output8: got 0x%0h, expected none", out8_data);
        end else begin
          got8_e = exp8_q.pop_front();
          check("out8_data_last", {23'd0, out8_last, out8_data}, {23'd0, got8_e});
        end
      end
    end
    p_ov   = out_valid;
    p_or   = out_ready;
    p_last = out_last;
    p_data = out_data;
    p_rst  = rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  // Presents one sample and returns just after the edge that accepted it.
  task automatic send(input logic [7:0] d);
    int  t = 0;
    bit  hs = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never seen for 0x%0h", d);
    end
  endtask

  task automatic send8(input logic [7:0] d);
    int  t = 0;
    bit  hs = 0;
    in8_valid = 1'b1;
    in8_data  = d;
    do begin
      @(negedge clk);
      hs = in8_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL send8_timeout: in_ready never seen for 0x%0h", d);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic pat [7];

  initial begin
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in8_valid  = 1'b0;
    in8_data   = '0;
    out8_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in8_ready", {31'd0, in8_ready}, 32'd1);
    mon_en = 1;
    @(posedge clk);
    #1;

    // Basic reorder
    push4(8'h10, 8'h12, 8'h11, 8'h13);
    send(8'h10); send(8'h11); send(8'h12); send(8'h13);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure
    push4(8'h10, 8'h12, 8'h11, 8'h13);
    send(8'h10); send(8'h11); send(8'h12); send(8'h13);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      check("busy_during_bp", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("busy_after_bp", {31'd0, busy}, 32'd0);
    wait_drain();

    // Input gaps, then 0xFF offered throughout DRAIN
    push4(8'hA0, 8'hA2, 8'hA1, 8'hA3);
    send(8'hA0); in_valid = 1'b0; @(posedge clk); #1;
    send(8'hA1); in_valid = 1'b0; @(posedge clk); #1;
    send(8'hA2); in_valid = 1'b0; @(posedge clk); #1;
    send(8'hA3);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back frames
    frame_start  = -1;
    check_period = 1;
    push4(8'h40, 8'h42, 8'h41, 8'h43);
    push4(8'h50, 8'h52, 8'h51, 8'h53);
    push4(8'h60, 8'h62, 8'h61, 8'h63);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) send(8'(8'h40 + 8'h10 * f + k));
    end
    in_valid = 1'b0;
    wait_drain();
    check_period = 0;

    // Reset during FILL after two samples
    send(8'h77); send(8'h78);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_forced_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_fill_reset", {31'd0, in_ready}, 32'd1);
    push4(8'h20, 8'h22, 8'h21, 8'h23);
    send(8'h20); send(8'h21); send(8'h22); send(8'h23);
    in_valid = 1'b0;
    wait_drain();

    // Reset during DRAIN
    out_ready = 1'b0;
    send(8'h30); send(8'h31); send(8'h32); send(8'h33);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("busy_before_drain_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("out_valid_after_drain_reset", {31'd0, out_valid}, 32'd0);
    check("busy_after_drain_reset", {31'd0, busy}, 32'd0);
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_drain_reset", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    push4(8'h20, 8'h22, 8'h21, 8'h23);
    send(8'h20); send(8'h21); send(8'h22); send(8'h23);
    in_valid = 1'b0;
    wait_drain();

    // N_LOG2 = 3 permutation
    exp8_q.push_back({1'b0, 8'd0});
    exp8_q.push_back({1'b0, 8'd4});
    exp8_q.push_back({1'b0, 8'd2});
    exp8_q.push_back({1'b0, 8'd6});
    exp8_q.push_back({1'b0, 8'd1});
    exp8_q.push_back({1'b0, 8'd5});
    exp8_q.push_back({1'b0, 8'd3});
    exp8_q.push_back({1'b1, 8'd7});
    for (int k = 0; k < 8; k++) send8(8'(k));
    in8_valid = 1'b0;
    for (int t = 0; t < 100 && (exp8_q.size() != 0 || busy8); t++) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("exp8_q_empty", exp8_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
